// File: rtl/sata_wrapper_define_pkg.sv
// Shared SATA command types: H2D/D2H register FIS views over one command word.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package sata_wrapper_define;

    // ATA status register bit positions
    localparam int ATA_STS_ERR = 0;
    localparam int ATA_STS_BSY = 7;

    // Host-to-device register FIS fields
    typedef struct packed {
        logic [7:0]  command;
        logic [15:0] features;
        logic [47:0] lba;
        logic [15:0] count;
        logic [7:0]  device;
        logic [7:0]  control;
    } h2d_t;

    // Device-to-host register FIS fields (same width as h2d_t)
    typedef struct packed {
        logic [7:0]  status;
        logic [7:0]  error;
        logic [47:0] lba;
        logic [15:0] count;
        logic [7:0]  device;
        logic [15:0] rsvd;
    } d2h_t;

    typedef union packed {
        h2d_t h2d;
        d2h_t d2h;
    } cmd_t;

    // Index width for n requesters, never below one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sata_rr_arbiter.sv
// Round-robin pick: first requester after 'last', wrapping modulo NREQ.
// Latency: combinational.
// Backpressure: none; grant is all-zero when nothing requests.
module sata_rr_arbiter
    import sata_wrapper_define::*;
#(
    parameter  int NREQ = 2,
    localparam int IW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] grant
);

    // Walk priorities last+1, last+2, ... and take the first active requester
    always_comb begin
        logic found;
        grant = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req[i] && (((int'(last) + k) % NREQ) == i)) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sata_cmd_scheduler.sv
// Serialises H2D commands from NREQ requesters and pairs each with its D2H reply or a timeout.
// Latency: grant registered one cycle after request seen in IDLE; resp_valid one cycle after D2H/timeout.
// Backpressure: one command in flight; requesters hold req_valid until granted, m_req held until m_ack.
module sata_cmd_scheduler
    import sata_wrapper_define::*;
#(
    parameter  int NREQ        = 2,
    parameter  int TIMEOUT_CYC = 1000000,
    localparam int IW          = idx_width(NREQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    input  cmd_t [NREQ-1:0]    req_cmd,
    output logic [NREQ-1:0]    req_grant,
    output logic               resp_valid,
    output logic [IW-1:0]      resp_id,
    output cmd_t               resp_d2h,
    output logic               resp_err,
    output logic               resp_timeout,
    output cmd_t               m_cmd,
    output logic               m_req,
    input  logic               m_ack,
    input  cmd_t               s_cmd,
    input  logic               s_req,
    output logic               s_ack,
    output logic               busy,
    output logic               unsol_d2h
);

    localparam int            TW    = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_D2H,
        ST_RESP
    } state_t;

    state_t          state;
    logic [IW-1:0]   last_idx;
    logic [TW-1:0]   tcnt;
    logic [NREQ-1:0] arb_grant;
    logic [IW-1:0]   sel_idx;
    cmd_t            sel_cmd;
    logic            s_take;

    sata_rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req   (req_valid),
        .last  (last_idx),
        .grant (arb_grant)
    );

    // A D2H is taken only when s_ack was low last cycle, so s_ack never repeats back-to-back
    assign s_take = s_req && !s_ack;
    assign busy   = (state != ST_IDLE);

    // Encode the one-hot arbiter grant into an index and the matching command
    always_comb begin
        sel_idx = '0;
        sel_cmd = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_grant[i]) begin
                sel_idx = IW'(i);
                sel_cmd = req_cmd[i];
            end
        end
    end

    // Command FSM: grant, issue H2D, wait for D2H or timeout, report completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            last_idx     <= IW'(NREQ - 1);
            tcnt         <= '0;
            req_grant    <= '0;
            resp_valid   <= 1'b0;
            resp_id      <= '0;
            resp_d2h     <= '0;
            resp_err     <= 1'b0;
            resp_timeout <= 1'b0;
            m_cmd        <= '0;
            m_req        <= 1'b0;
            s_ack        <= 1'b0;
            unsol_d2h    <= 1'b0;
        end else begin
            req_grant  <= '0;
            resp_valid <= 1'b0;
            s_ack      <= 1'b0;
            unsol_d2h  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (s_take) begin
                        s_ack     <= 1'b1;
                        unsol_d2h <= 1'b1;
                    end
                    if (|req_valid) begin
                        req_grant <= arb_grant;
                        m_cmd     <= sel_cmd;
                        resp_id   <= sel_idx;
                        last_idx  <= sel_idx;
                        m_req     <= 1'b1;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (s_take) begin
                        s_ack     <= 1'b1;
                        unsol_d2h <= 1'b1;
                    end
                    if (m_ack) begin
                        m_req <= 1'b0;
                        tcnt  <= '0;
                        state <= ST_WAIT_D2H;
                    end
                end
                ST_WAIT_D2H: begin
                    // A response in the final counted cycle still beats the timeout
                    if (s_take) begin
                        s_ack        <= 1'b1;
                        resp_d2h     <= s_cmd;
                        resp_err     <= s_cmd.d2h.status[ATA_STS_ERR];
                        resp_timeout <= 1'b0;
                        resp_valid   <= 1'b1;
                        state        <= ST_RESP;
                    end else if (tcnt >= TLAST) begin
                        resp_err     <= 1'b1;
                        resp_timeout <= 1'b1;
                        resp_valid   <= 1'b1;
                        state        <= ST_RESP;
                    end else if (tcnt != '1) begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    resp_err     <= 1'b0;
                    resp_timeout <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sata_cmd_scheduler.sv
// Self-checking bench for sata_cmd_scheduler: vector table, corner sequences, random traffic vs model.
// Latency: n/a.
// Backpressure: bench plays both the requesters and the transport layer.
module tb_sata_cmd_scheduler;
    import sata_wrapper_define::*;

    localparam int NREQ = 2;
    localparam int TO   = 16;

    logic            clk;
    logic            rst_n;
    logic [NREQ-1:0] req_valid;
    cmd_t [NREQ-1:0] req_cmd;
    logic [NREQ-1:0] req_grant;
    logic            resp_valid;
    logic [0:0]      resp_id;
    cmd_t            resp_d2h;
    logic            resp_err;
    logic            resp_timeout;
    cmd_t            m_cmd;
    logic            m_req;
    logic            m_ack;
    cmd_t            s_cmd;
    logic            s_req;
    logic            s_ack;
    logic            busy;
    logic            unsol_d2h;

    int   errors = 0;
    int   checks = 0;
    int   model_last;
    cmd_t prev_d2h;

    typedef struct {
        logic [NREQ-1:0] valid;
        int              ack_dly;
        int              rsp_dly;
        logic [7:0]      status;
        logic [7:0]      error;
        logic [NREQ-1:0] exp_gnt;
        logic            exp_err;
        logic            exp_to;
    } vec_t;

    vec_t tbl[9];

    sata_cmd_scheduler #(
        .NREQ        (NREQ),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_cmd      (req_cmd),
        .req_grant    (req_grant),
        .resp_valid   (resp_valid),
        .resp_id      (resp_id),
        .resp_d2h     (resp_d2h),
        .resp_err     (resp_err),
        .resp_timeout (resp_timeout),
        .m_cmd        (m_cmd),
        .m_req        (m_req),
        .m_ack        (m_ack),
        .s_cmd        (s_cmd),
        .s_req        (s_req),
        .s_ack        (s_ack),
        .busy         (busy),
        .unsol_d2h    (unsol_d2h)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c = '0;
        c.h2d.command = 8'($urandom());
        c.h2d.lba     = {16'($urandom()), 32'($urandom())};
        c.h2d.count   = 16'($urandom());
        c.h2d.device  = 8'($urandom());
        return c;
    endfunction

    function automatic cmd_t mk_d2h(input logic [7:0] st, input logic [7:0] er);
        cmd_t c;
        c = '0;
        c.d2h.status = st;
        c.d2h.error  = er;
        c.d2h.lba    = {16'($urandom()), 32'($urandom())};
        c.d2h.count  = 16'($urandom());
        c.d2h.device = 8'($urandom());
        return c;
    endfunction

    // Next winner: first valid requester after the last granted one, wrapping
    function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (last + k) % NREQ;
            if (v[1'(c)]) return c;
        end
        return -1;
    endfunction

    // Raise requesters not already pending, each with a fresh command
    task automatic raise(input logic [NREQ-1:0] mask);
        for (int r = 0; r < NREQ; r++) begin
            if (mask[1'(r)] && !req_valid[1'(r)]) begin
                req_cmd[1'(r)]   = rand_cmd();
                req_valid[1'(r)] = 1'b1;
            end
        end
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, ".req_grant"},    128'(req_grant),    128'(0));
        check({tag, ".resp_valid"},   128'(resp_valid),   128'(0));
        check({tag, ".resp_err"},     128'(resp_err),     128'(0));
        check({tag, ".resp_timeout"}, 128'(resp_timeout), 128'(0));
        check({tag, ".m_req"},        128'(m_req),        128'(0));
        check({tag, ".s_ack"},        128'(s_ack),        128'(0));
        check({tag, ".busy"},         128'(busy),         128'(0));
        check({tag, ".unsol_d2h"},    128'(unsol_d2h),    128'(0));
        check({tag, ".m_cmd"},        128'(m_cmd),        128'(0));
        check({tag, ".resp_d2h"},     128'(resp_d2h),     128'(0));
        check({tag, ".resp_id"},      128'(resp_id),      128'(0));
    endtask

    // One full command: grant, m_ack after ack_dly extra cycles, D2H after rsp_dly (or timeout if <0)
    task automatic run_txn(input string tag, input logic [NREQ-1:0] exp_gnt, input int ack_dly,
                           input int rsp_dly, input cmd_t d2h, input logic exp_err, input logic exp_to);
        int   n;
        int   lat;
        int   exp_idx;
        cmd_t exp_cmd;
        cmd_t exp_d2h;
        exp_cmd = '0;
        exp_idx = 0;
        for (int r = 0; r < NREQ; r++) begin
            if (exp_gnt[1'(r)]) begin
                exp_cmd = req_cmd[1'(r)];
                exp_idx = r;
            end
        end
        n = 0;
        while (req_grant == '0 && n < 40) begin
            step();
            n++;
        end
        check({tag, ".grant"}, 128'(req_grant), 128'(exp_gnt));
        check({tag, ".m_cmd"}, 128'(m_cmd),     128'(exp_cmd));
        check({tag, ".m_req"}, 128'(m_req),     128'(1));
        check({tag, ".busy"},  128'(busy),      128'(1));
        req_valid  = req_valid & ~exp_gnt;
        model_last = exp_idx;
        step();
        check({tag, ".grant_pulse"}, 128'(req_grant), 128'(0));
        repeat (ack_dly) step();
        check({tag, ".m_req_hold"}, 128'(m_req), 128'(1));
        m_ack = 1'b1;
        step();
        m_ack = 1'b0;
        check({tag, ".m_req_drop"}, 128'(m_req), 128'(0));
        lat = 0;
        if (rsp_dly >= 0) begin
            repeat (rsp_dly) begin
                step();
                lat++;
            end
            s_cmd = d2h;
            s_req = 1'b1;
        end
        n = 0;
        while (!resp_valid && n < 40) begin
            step();
            lat++;
            n++;
        end
        s_req   = 1'b0;
        exp_d2h = (rsp_dly >= 0) ? d2h : prev_d2h;
        check({tag, ".resp_valid"},   128'(resp_valid),   128'(1));
        check({tag, ".latency"},      128'(lat),          128'((rsp_dly >= 0) ? rsp_dly + 1 : TO));
        check({tag, ".resp_id"},      128'(resp_id),      128'(exp_idx));
        check({tag, ".resp_err"},     128'(resp_err),     128'(exp_err));
        check({tag, ".resp_timeout"}, 128'(resp_timeout), 128'(exp_to));
        check({tag, ".resp_d2h"},     128'(resp_d2h),     128'(exp_d2h));
        check({tag, ".s_ack"},        128'(s_ack),        128'(rsp_dly >= 0));
        prev_d2h = exp_d2h;
        step();
        check({tag, ".resp_pulse"}, 128'(resp_valid), 128'(0));
        check({tag, ".idle"},       128'(busy),       128'(0));
        check({tag, ".s_ack_drop"}, 128'(s_ack),      128'(0));
    endtask

    initial begin
        int n;
        int rv;
        tbl[0] = '{2'b01, 4,  2, 8'h50, 8'h00, 2'b01, 1'b0, 1'b0};
        tbl[1] = '{2'b11, 1,  0, 8'h50, 8'h00, 2'b10, 1'b0, 1'b0};
        tbl[2] = '{2'b11, 0,  5, 8'h50, 8'h00, 2'b01, 1'b0, 1'b0};
        tbl[3] = '{2'b11, 2,  1, 8'h50, 8'h00, 2'b10, 1'b0, 1'b0};
        tbl[4] = '{2'b10, 0,  3, 8'h51, 8'h04, 2'b01, 1'b1, 1'b0};
        tbl[5] = '{2'b00, 1, -1, 8'h50, 8'h00, 2'b10, 1'b1, 1'b1};
        tbl[6] = '{2'b01, 0, 15, 8'h50, 8'h00, 2'b01, 1'b0, 1'b0};
        tbl[7] = '{2'b11, 3,  0, 8'h41, 8'h10, 2'b10, 1'b1, 1'b0};
        tbl[8] = '{2'b00, 0,  3, 8'hD0, 8'h00, 2'b01, 1'b0, 1'b0};

        rst_n      = 1'b0;
        req_valid  = '0;
        req_cmd    = '0;
        m_ack      = 1'b0;
        s_cmd      = '0;
        s_req      = 1'b0;
        model_last = NREQ - 1;
        prev_d2h   = '0;
        repeat (3) step();
        check_idle_reset("reset");
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 9; i++) begin
            raise(tbl[i].valid);
            run_txn($sformatf("vec%0d", i), tbl[i].exp_gnt, tbl[i].ack_dly, tbl[i].rsp_dly,
                    mk_d2h(tbl[i].status, tbl[i].error), tbl[i].exp_err, tbl[i].exp_to);
        end

        // Unsolicited D2H while idle
        s_cmd = mk_d2h(8'h50, 8'h00);
        s_req = 1'b1;
        step();
        check("unsol.s_ack", 128'(s_ack),     128'(1));
        check("unsol.pulse", 128'(unsol_d2h), 128'(1));
        check("unsol.busy",  128'(busy),      128'(0));
        s_req = 1'b0;
        rv = 0;
        if (resp_valid) rv++;
        step();
        check("unsol.s_ack_drop", 128'(s_ack),     128'(0));
        check("unsol.pulse_drop", 128'(unsol_d2h), 128'(0));
        repeat (3) begin
            if (resp_valid) rv++;
            step();
        end
        check("unsol.no_resp",  128'(rv),       128'(0));
        check("unsol.resp_d2h", 128'(resp_d2h), 128'(prev_d2h));

        // Reset while waiting for D2H abandons the command
        raise(2'b01);
        n = 0;
        while (req_grant == '0 && n < 40) begin
            step();
            n++;
        end
        check("rst_mid.grant", 128'(req_grant), 128'(2'b01));
        req_valid = '0;
        step();
        m_ack = 1'b1;
        step();
        m_ack = 1'b0;
        repeat (3) step();
        check("rst_mid.busy", 128'(busy), 128'(1));
        rst_n = 1'b0;
        #1;
        check_idle_reset("rst_mid");
        raise(2'b11);
        rv = 0;
        repeat (3) begin
            step();
            if (resp_valid) rv++;
        end
        check("rst_mid.no_resp", 128'(rv), 128'(0));
        model_last = NREQ - 1;
        prev_d2h   = '0;
        rst_n      = 1'b1;

        // Both requesters kept busy: strict alternation starting at 0
        for (int i = 0; i < 4; i++) begin
            raise(2'b11);
            run_txn($sformatf("rr%0d", i), (i % 2 == 0) ? 2'b01 : 2'b10, 1, 3,
                    mk_d2h(8'h50, 8'h00), 1'b0, 1'b0);
        end

        // Random traffic against the round-robin / completion model
        for (int t = 0; t < 40; t++) begin
            logic [NREQ-1:0] m;
            int              w;
            int              rd;
            logic [7:0]      st;
            for (int r = 0; r < NREQ; r++) begin
                if (req_valid[1'(r)] && $urandom_range(0, 5) == 0) req_valid[1'(r)] = 1'b0;
            end
            m = NREQ'($urandom());
            if ((req_valid | m) == '0) m = NREQ'(1 << $urandom_range(0, NREQ - 1));
            raise(m);
            w  = rr_pick(req_valid, model_last);
            rd = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 15));
            st = 8'($urandom());
            run_txn($sformatf("rnd%0d", t), NREQ'(1 << w), int'($urandom_range(0, 4)), rd,
                    mk_d2h(st, 8'($urandom())), (rd < 0) | st[ATA_STS_ERR], rd < 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
